ps2_scan_decoder: RTL and testbench

//  Sits between the PS/2 keyboard controller and the MIO bus key port.

---
 rtl/ps2_scan_decoder_pkg.sv | 23 ++
 rtl/ps2_scan_decoder_if.sv | 43 ++++
 rtl/ps2_ascii_rom.sv | 60 ++++++
 rtl/ps2_scan_decoder.sv | 132 +++++++++++++
 tb/tb_ps2_scan_decoder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// Shared scancode constants, event layout and FSM encoding
// for the PS/2 scancode decoder slice.
package ps2_evt_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  localparam int EVT_EXT     = 9;
  localparam int EVT_BRK     = 8;
  localparam int EVT_CODE_HI = 7;
  localparam int EVT_CODE_LO = 0;

  typedef logic [9:0] evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_SETTLE
  } state_t;

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Key-port bundle: controller byte handshake plus CPU event FIFO.
// master = host side, slave = decoder. PS2_ASCII_EN adds evt_ascii.
interface ps2_scan_decoder_if #(
  parameter int DEPTH_LOG2 = 4
);
  import ps2_evt_pkg::*;

  logic [7:0]        kb_data;
  logic              kb_ready;
  logic              kb_rdn;
  logic              evt_rd;
  logic              ovf_clr;
  evt_t              evt_data;
  logic              evt_valid;
  logic [DEPTH_LOG2:0] evt_count;
  logic              overflow;
`ifdef PS2_ASCII_EN
  logic [7:0]        evt_ascii;
`endif

  modport master (
    output kb_data, kb_ready,
    output evt_rd, ovf_clr,
    input  kb_rdn,
    input  evt_data, evt_valid,
    input  evt_count, overflow
`ifdef PS2_ASCII_EN
    , input evt_ascii
`endif
  );

  modport slave (
    input  kb_data, kb_ready,
    input  evt_rd, ovf_clr,
    output kb_rdn,
    output evt_data, evt_valid,
    output evt_count, overflow
`ifdef PS2_ASCII_EN
    , output evt_ascii
`endif
  );

endinterface

// File: rtl/ps2_ascii_rom.sv
// Set-2 make code -> ASCII. In: evt (head event). Out: ascii,
// 0 for break/extended events or unmapped codes.
module ps2_ascii_rom
  import ps2_evt_pkg::*;
(
  input  evt_t       evt,
  output logic [7:0] ascii
);

  logic [7:0] code;
  assign code = evt[EVT_CODE_HI:EVT_CODE_LO];

  always_comb begin
    ascii = 8'h00;
    if (!evt[EVT_EXT] && !evt[EVT_BRK]) begin
      case (code)
        8'h1C: ascii = 8'h61;
        8'h32: ascii = 8'h62;
        8'h21: ascii = 8'h63;
        8'h23: ascii = 8'h64;
        8'h24: ascii = 8'h65;
        8'h2B: ascii = 8'h66;
        8'h34: ascii = 8'h67;
        8'h33: ascii = 8'h68;
        8'h43: ascii = 8'h69;
        8'h3B: ascii = 8'h6A;
        8'h42: ascii = 8'h6B;
        8'h4B: ascii = 8'h6C;
        8'h3A: ascii = 8'h6D;
        8'h31: ascii = 8'h6E;
        8'h44: ascii = 8'h6F;
        8'h4D: ascii = 8'h70;
        8'h15: ascii = 8'h71;
        8'h2D: ascii = 8'h72;
        8'h1B: ascii = 8'h73;
        8'h2C: ascii = 8'h74;
        8'h3C: ascii = 8'h75;
        8'h2A: ascii = 8'h76;
        8'h1D: ascii = 8'h77;
        8'h22: ascii = 8'h78;
        8'h35: ascii = 8'h79;
        8'h1A: ascii = 8'h7A;
        8'h45: ascii = 8'h30;
        8'h16: ascii = 8'h31;
        8'h1E: ascii = 8'h32;
        8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34;
        8'h2E: ascii = 8'h35;
        8'h36: ascii = 8'h36;
        8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38;
        8'h46: ascii = 8'h39;
        8'h29: ascii = 8'h20;
        8'h5A: ascii = 8'h0D;
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 scancode decoder: clk, clrn (async low), bus (slave) carrying
// kb_data/kb_ready/kb_rdn and evt_rd/ovf_clr/evt_*/overflow. Macro PS2_ASCII_EN.
module ps2_scan_decoder
  import ps2_evt_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input logic clk,
  input logic clrn,
  ps2_scan_decoder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  localparam cnt_t FULL = cnt_t'(DEPTH);

  state_t     state, state_n;
  logic [7:0] byte_r;
  logic       ext_f, brk_f;
  logic       ext_n, brk_n;
  logic       in_pop, push_req;

  evt_t mem [DEPTH];
  ptr_t wr_ptr, rd_ptr;
  cnt_t count;
  logic ovf_r;
  logic full, empty;
  logic pop, wr_en, drop;
  evt_t head;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (bus.kb_ready) state_n = ST_POP;
      ST_POP:    state_n = ST_SETTLE;
      ST_SETTLE: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    in_pop     = (state == ST_POP);
    bus.kb_rdn = !in_pop;
  end

  // Prefix bytes only arm flags; error and data bytes consume them.
  always_comb begin
    push_req = 1'b0;
    ext_n    = ext_f;
    brk_n    = brk_f;
    if (in_pop) begin
      unique case (1'b1)
        byte_r == SC_EXT: ext_n = 1'b1;
        byte_r == SC_BRK: brk_n = 1'b1;
        byte_r == SC_ERR0,
        byte_r == SC_ERR1: begin
          ext_n = 1'b0;
          brk_n = 1'b0;
        end
        default: begin
          push_req = 1'b1;
          ext_n    = 1'b0;
          brk_n    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      byte_r <= '0;
      ext_f  <= 1'b0;
      brk_f  <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.kb_ready)
        byte_r <= bus.kb_data;
      ext_f <= ext_n;
      brk_f <= brk_n;
    end
  end

  // A pop on a full FIFO frees the head slot, which is exactly
  // where wr_ptr points, so a simultaneous push is always safe.
  assign full  = (count == FULL);
  assign empty = (count == '0);
  assign pop   = bus.evt_rd && !empty;
  assign wr_en = push_req && (!full || pop);
  assign drop  = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {ext_f, brk_f, byte_r};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)             ovf_r <= 1'b1;
      else if (bus.ovf_clr) ovf_r <= 1'b0;
    end
  end

  assign head          = empty ? '0 : mem[rd_ptr];
  assign bus.evt_data  = head;
  assign bus.evt_valid = !empty;
  assign bus.evt_count = count;
  assign bus.overflow  = ovf_r;

`ifdef PS2_ASCII_EN
  ps2_ascii_rom u_rom (
    .evt   (head),
    .ascii (bus.evt_ascii)
  );
`endif

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: vector table of byte sequences plus
// hand sequences for FIFO full/overflow, same-cycle pop and reset.
module tb_ps2_scan_decoder;

  logic clk;
  logic clrn;

  ps2_scan_decoder_if #(.DEPTH_LOG2(4)) bus ();

  ps2_scan_decoder #(.DEPTH_LOG2(4)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] b;
    logic [9:0]  ev;
  } vec_t;

  vec_t       vt [7];
  logic [7:0] kb_q [$];
  logic [9:0] exp_q [$];
  int         rdn_q [$];
  int         cyc;
  int         n_chk;
  int         n_fail;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic kb_sync();
    bus.kb_ready = (kb_q.size() != 0);
    bus.kb_data  = (kb_q.size() != 0) ? kb_q[0] : 8'h00;
  endtask

  // Controller model: pops its head on a sampled low kb_rdn.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.kb_rdn == 1'b0) begin
      rdn_q.push_back(cyc);
      if (kb_q.size() != 0) void'(kb_q.pop_front());
    end
    kb_sync();
  endtask

  task automatic send(input logic [7:0] b);
    kb_q.push_back(b);
    kb_sync();
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (kb_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: drain timeout, got busy expected idle", nm);
    end
    repeat (3) tick();
  endtask

  task automatic wait_rdn(input string nm);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (bus.kb_rdn != 1'b0 && t < 20);
    if (bus.kb_rdn != 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: kb_rdn got 1 expected 0", nm);
    end
  endtask

  task automatic read_evt(input string nm);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard got empty expected entry", nm);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_valid"}, 32'(bus.evt_valid), 32'd1);
      check({nm, "_data"}, 32'(bus.evt_data), 32'(e));
    end
    bus.evt_rd = 1'b1;
    tick();
    bus.evt_rd = 1'b0;
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_rdn"}, 32'(bus.kb_rdn), 32'd1);
    check({nm, "_valid"}, 32'(bus.evt_valid), 32'd0);
    check({nm, "_count"}, 32'(bus.evt_count), 32'd0);
    check({nm, "_data"}, 32'(bus.evt_data), 32'd0);
    check({nm, "_ovf"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    vt[0] = '{3'd1, 32'h1C000000, 10'h01C};
    vt[1] = '{3'd2, 32'hE0750000, 10'h275};
    vt[2] = '{3'd2, 32'hF01C0000, 10'h11C};
    vt[3] = '{3'd3, 32'hE0F07500, 10'h375};
    vt[4] = '{3'd3, 32'hF0FF1C00, 10'h01C};
    vt[5] = '{3'd2, 32'h005A0000, 10'h05A};
    vt[6] = '{3'd4, 32'hE000E01F, 10'h21F};

    clrn        = 1'b0;
    bus.evt_rd  = 1'b0;
    bus.ovf_clr = 1'b0;
    kb_sync();
    repeat (3) tick();
    check_reset_outs("reset");
    clrn = 1'b1;
    tick();

    // First event latency: visible the cycle after POP.
    send(8'h1C);
    wait_rdn("t1_rdn");
    check("t1_pop_valid", 32'(bus.evt_valid), 32'd0);
    tick();
    check("t1_rdn_width", 32'(bus.kb_rdn), 32'd1);
    check("t1_valid", 32'(bus.evt_valid), 32'd1);
    check("t1_data", 32'(bus.evt_data), 32'h01C);
    check("t1_count", 32'(bus.evt_count), 32'd1);
    exp_q.push_back(10'h01C);
    read_evt("t1_rd");

    for (int i = 0; i < 7; i++) begin
      rdn_q.delete();
      for (int k = 0; k < int'(vt[i].n); k++)
        send(vt[i].b[31-8*k -: 8]);
      exp_q.push_back(vt[i].ev);
      wait_drain($sformatf("v%0d", i));
      check($sformatf("v%0d_count", i), 32'(bus.evt_count), 32'd1);
      check($sformatf("v%0d_pulses", i), 32'(rdn_q.size()),
            32'(vt[i].n));
      for (int k = 1; k < rdn_q.size(); k++)
        check($sformatf("v%0d_gap%0d", i, k),
              32'(rdn_q[k] - rdn_q[k-1]), 32'd3);
      read_evt($sformatf("v%0d_rd", i));
      check($sformatf("v%0d_empty", i), 32'(bus.evt_count), 32'd0);
    end

    // Push and pop together on an empty FIFO: the pop is ignored.
    send(8'h1C);
    wait_rdn("pe_rdn");
    bus.evt_rd = 1'b1;
    tick();
    bus.evt_rd = 1'b0;
    check("pe_count", 32'(bus.evt_count), 32'd1);
    exp_q.push_back(10'h01C);
    read_evt("pe_rd");

`ifdef PS2_ASCII_EN
    send(8'h1C);
    wait_drain("asc_a");
    check("asc_a", 32'(bus.evt_ascii), 32'h61);
    exp_q.push_back(10'h01C);
    read_evt("asc_a_rd");
    send(8'hF0);
    send(8'h1C);
    wait_drain("asc_brk");
    check("asc_brk", 32'(bus.evt_ascii), 32'h00);
    exp_q.push_back(10'h11C);
    read_evt("asc_brk_rd");
    check("asc_empty", 32'(bus.evt_ascii), 32'h00);
`endif

    // Overflow: 17 pushes into 16 slots.
    for (int i = 0; i < 17; i++) begin
      send(8'h10 + 8'(i));
      if (i < 16) exp_q.push_back(10'h010 + 10'(i));
    end
    wait_drain("ovf");
    check("ovf_count", 32'(bus.evt_count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_head", 32'(bus.evt_data), 32'h010);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full FIFO, pop coinciding with push of 0x2A.
    send(8'h2A);
    wait_rdn("fp_rdn");
    check("fp_head", 32'(bus.evt_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    exp_q.push_back(10'h02A);
    bus.evt_rd = 1'b1;
    tick();
    bus.evt_rd = 1'b0;
    wait_drain("fp");
    check("fp_count", 32'(bus.evt_count), 32'd16);
    check("fp_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++)
      read_evt($sformatf("fp_rd%0d", i));
    check("fp_empty", 32'(bus.evt_count), 32'd0);

    // Read while empty is ignored.
    bus.evt_rd = 1'b1;
    tick();
    bus.evt_rd = 1'b0;
    tick();
    check("ue_count", 32'(bus.evt_count), 32'd0);
    check("ue_valid", 32'(bus.evt_valid), 32'd0);
    check("ue_data", 32'(bus.evt_data), 32'd0);

    // Reset during POP with one event buffered.
    send(8'h5A);
    wait_drain("rst_pre");
    check("rst_pre_count", 32'(bus.evt_count), 32'd1);
    send(8'h1C);
    wait_rdn("rst_rdn");
    #1 clrn = 1'b0;
    #1;
    check_reset_outs("rst_pop");
    tick();
    clrn = 1'b1;
    exp_q.delete();
    repeat (5) tick();
    check("rst_noreread", 32'(bus.evt_count), 32'd0);

    // Reset clears a pending E0 prefix.
    send(8'hE0);
    wait_rdn("rst_ext_rdn");
    tick();
    #1 clrn = 1'b0;
    #1 clrn = 1'b1;
    send(8'h1C);
    exp_q.push_back(10'h01C);
    wait_drain("rst_ext");
    read_evt("rst_ext_rd");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
